// File: rtl/vec_serializer.sv
// Vector-to-element serializer feeding a flagless sync_fifo; mirrors the FIFO count locally.
// Define VEC_SER_MSB_FIRST_EN to issue elements from NUM_ELEM-1 down to 0 instead of 0 upward.
module vec_serializer #(
  parameter int DATA_LEN   = 8,
  parameter int NUM_ELEM   = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         sys_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_LEN*NUM_ELEM-1:0] vec_in,
  output logic                         fifo_wr_en,
  output logic [DATA_LEN-1:0]          fifo_data,
  input  logic                         fifo_rd_en,
  output logic [ADDR_WIDTH:0]          occupancy,
  output logic                         busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_ELEM - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_OCC = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH+1:0] DEPTH_EXT = (ADDR_WIDTH + 2)'(DEPTH);

  state_t                       state, state_nx;
  logic [IDX_WIDTH-1:0]         idx, idx_nx;
  logic [IDX_WIDTH-1:0]         sel;
  logic [DATA_LEN*NUM_ELEM-1:0] shadow, shadow_nx;
  logic [DATA_LEN-1:0]          elem;
  logic                         wr_nx;
  logic [DATA_LEN-1:0]          data_nx;
  logic [ADDR_WIDTH:0]          occ_nx;
  logic                         space_ok;

  assign in_ready = (state == IDLE);
  assign busy     = (state == SHIFT);

  // Conservative: a write already in flight counts as occupied, a same-cycle read does not free space.
  assign space_ok = ({1'b0, occupancy} + (ADDR_WIDTH + 2)'(fifo_wr_en)) < DEPTH_EXT;

`ifdef VEC_SER_MSB_FIRST_EN
  assign sel = LAST_IDX - idx;
`else
  assign sel = idx;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    elem = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (sel == IDX_WIDTH'(k)) elem = shadow[k*DATA_LEN +: DATA_LEN];
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    shadow_nx = shadow;
    wr_nx     = 1'b0;
    data_nx   = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          shadow_nx = vec_in;
          idx_nx    = '0;
          state_nx  = SHIFT;
        end
      end
      SHIFT: begin
        if (space_ok) begin
          wr_nx   = 1'b1;
          data_nx = elem;
          if (idx == LAST_IDX) begin
            idx_nx   = '0;
            state_nx = IDLE;
          end else begin
            idx_nx = idx + IDX_WIDTH'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Count rules follow the FIFO: 11 holds, which also covers its empty pass-through case.
  always_comb begin
    occ_nx = occupancy;
    case ({fifo_wr_en, fifo_rd_en})
      2'b10:   if (occupancy != DEPTH_OCC) occ_nx = occupancy + (ADDR_WIDTH + 1)'(1);
      2'b01:   if (occupancy != '0)        occ_nx = occupancy - (ADDR_WIDTH + 1)'(1);
      default: occ_nx = occupancy;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      fifo_wr_en <= 1'b0;
      fifo_data  <= '0;
      occupancy  <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      shadow     <= shadow_nx;
      fifo_wr_en <= wr_nx;
      fifo_data  <= data_nx;
      occupancy  <= occ_nx;
    end
  end

endmodule

// File: tb/tb_vec_serializer.sv
// Directed bench for vec_serializer: ordering, latency, FIFO-full stall, reads, async reset, throughput.
// Expected element order follows VEC_SER_MSB_FIRST_EN the same way the design does.
module tb_vec_serializer;

  localparam int DATA_LEN   = 8;
  localparam int NUM_ELEM   = 4;
  localparam int IDX_WIDTH  = 2;
  localparam int DEPTH      = 8;
  localparam int ADDR_WIDTH = 3;

  logic                         clk;
  logic                         sys_rst_n;
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_LEN*NUM_ELEM-1:0] vec_in;
  logic                         fifo_wr_en;
  logic [DATA_LEN-1:0]          fifo_data;
  logic                         fifo_rd_en;
  logic [ADDR_WIDTH:0]          occupancy;
  logic                         busy;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_LEN-1:0] wr_log[$];

  vec_serializer #(
    .DATA_LEN(DATA_LEN), .NUM_ELEM(NUM_ELEM), .IDX_WIDTH(IDX_WIDTH),
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .vec_in(vec_in), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .occupancy(occupancy), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every element written into the FIFO, sampled mid-cycle.
  always @(negedge clk) begin
    if (sys_rst_n && fifo_wr_en) wr_log.push_back(fifo_data);
  end

  function automatic int ord(input int i);
`ifdef VEC_SER_MSB_FIRST_EN
    return NUM_ELEM - 1 - i;
`else
    return i;
`endif
  endfunction

  function automatic logic [DATA_LEN-1:0] elem_of(input int v, input int e);
    return DATA_LEN'(16 * (v + 1) + e + 1);
  endfunction

  function automatic logic [DATA_LEN*NUM_ELEM-1:0] mk_vec(input int v);
    logic [DATA_LEN*NUM_ELEM-1:0] r;
    for (int e = 0; e < NUM_ELEM; e++) r[e*DATA_LEN +: DATA_LEN] = elem_of(v, e);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and return just after its accepting edge; vec_in is scrambled afterwards.
  task automatic send(input logic [DATA_LEN*NUM_ELEM-1:0] v);
    bit done = 0;
    in_valid = 1'b1;
    vec_in   = v;
    for (int c = 0; c < 50 && !done; c++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    vec_in   = 32'hDEADBEEF;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL handshake_timeout: in_ready never seen, required 1");
    end
  endtask

  task automatic drain();
    fifo_rd_en = 1'b1;
    repeat (DEPTH + 2) tick();
    fifo_rd_en = 1'b0;
    n_vec++;
    if (occupancy !== '0) begin
      n_err++;
      $display("FAIL drain_occupancy: got %0d, required 0", occupancy);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; in_valid = 1'b0; vec_in = '0; fifo_rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec += 5;
    if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b, required 0", fifo_wr_en); end
    if (fifo_data !== '0)    begin n_err++; $display("FAIL reset_data: got %h, required 00", fifo_data); end
    if (occupancy !== '0)    begin n_err++; $display("FAIL reset_occupancy: got %0d, required 0", occupancy); end
    if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    #3 sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [DATA_LEN-1:0] exp_e[NUM_ELEM];
    exp_e[0] = 8'h11; exp_e[1] = 8'h22; exp_e[2] = 8'h33; exp_e[3] = 8'h44;
    wr_log.delete();
    send(32'h44332211);
    n_vec += 3;
    if (busy !== 1'b1)       begin n_err++; $display("FAIL basic_busy: got %b, required 1", busy); end
    if (in_ready !== 1'b0)   begin n_err++; $display("FAIL basic_in_ready_low: got %b, required 0", in_ready); end
    if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL basic_latency: wr_en got %b at E0, required 0", fifo_wr_en); end
    for (int i = 0; i < NUM_ELEM; i++) begin
      tick();
      n_vec++;
      if (fifo_wr_en !== 1'b1 || fifo_data !== exp_e[ord(i)]) begin
        n_err++;
        $display("FAIL basic_elem%0d: got wr=%b data=%h, required wr=1 data=%h",
                 i, fifo_wr_en, fifo_data, exp_e[ord(i)]);
      end
    end
    tick();
    n_vec += 3;
    if (fifo_wr_en !== 1'b0 || fifo_data !== '0) begin
      n_err++; $display("FAIL basic_idle_out: got wr=%b data=%h, required wr=0 data=00", fifo_wr_en, fifo_data);
    end
    if (in_ready !== 1'b1)  begin n_err++; $display("FAIL basic_in_ready_back: got %b, required 1", in_ready); end
    if (occupancy !== 4'd4) begin n_err++; $display("FAIL basic_occupancy: got %0d, required 4", occupancy); end
    drain();
  endtask

  task automatic test_back_to_back();
    wr_log.delete();
    for (int v = 0; v < 3; v++) send(mk_vec(v));
    repeat (6) tick();
    n_vec += 4;
    if (wr_log.size() != 8)  begin n_err++; $display("FAIL b2b_write_count: got %0d, required 8", wr_log.size()); end
    if (occupancy !== 4'd8)  begin n_err++; $display("FAIL b2b_full_occupancy: got %0d, required 8", occupancy); end
    if (busy !== 1'b1)       begin n_err++; $display("FAIL b2b_stall_busy: got %b, required 1", busy); end
    if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL b2b_stall_wr_en: got %b, required 0", fifo_wr_en); end
    for (int p = 0; p < 4; p++) begin
      fifo_rd_en = 1'b1;
      tick();
      fifo_rd_en = 1'b0;
      repeat (4) tick();
      n_vec += 2;
      if (wr_log.size() != 9 + p) begin
        n_err++; $display("FAIL b2b_after_read%0d_count: got %0d, required %0d", p, wr_log.size(), 9 + p);
      end
      if (occupancy !== 4'd8) begin
        n_err++; $display("FAIL b2b_after_read%0d_occupancy: got %0d, required 8", p, occupancy);
      end
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_busy: got %b, required 0", busy); end
    for (int i = 0; i < 12 && i < wr_log.size(); i++) begin
      n_vec++;
      if (wr_log[i] !== elem_of(i / NUM_ELEM, ord(i % NUM_ELEM))) begin
        n_err++;
        $display("FAIL b2b_data%0d: got %h, required %h", i, wr_log[i], elem_of(i / NUM_ELEM, ord(i % NUM_ELEM)));
      end
    end
    drain();
  endtask

  task automatic test_stream_read();
    int max_occ = 0;
    int wr_cycles = 0;
    fifo_rd_en = 1'b1;
    wr_log.delete();
    send(mk_vec(5));
    for (int c = 0; c < 8; c++) begin
      tick();
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (c < NUM_ELEM && fifo_wr_en) wr_cycles++;
    end
    fifo_rd_en = 1'b0;
    n_vec += 3;
    if (max_occ > 1)              begin n_err++; $display("FAIL rd_stream_max_occupancy: got %0d, required <=1", max_occ); end
    if (wr_cycles != NUM_ELEM)    begin n_err++; $display("FAIL rd_stream_no_stall: got %0d consecutive writes, required 4", wr_cycles); end
    if (occupancy !== '0)         begin n_err++; $display("FAIL rd_stream_final_occupancy: got %0d, required 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    send(mk_vec(6));
    tick();
    tick();
    #2 sys_rst_n = 1'b0;
    #1;
    n_vec += 5;
    if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL midrst_wr_en: got %b, required 0", fifo_wr_en); end
    if (fifo_data !== '0)    begin n_err++; $display("FAIL midrst_data: got %h, required 00", fifo_data); end
    if (occupancy !== '0)    begin n_err++; $display("FAIL midrst_occupancy: got %0d, required 0", occupancy); end
    if (busy !== 1'b0)       begin n_err++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    if (in_ready !== 1'b1)   begin n_err++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
    #3 sys_rst_n = 1'b1;
    tick();
    wr_log.delete();
    send(mk_vec(7));
    repeat (6) tick();
    n_vec += 3;
    if (wr_log.size() != NUM_ELEM) begin
      n_err++; $display("FAIL midrst_new_count: got %0d, required %0d", wr_log.size(), NUM_ELEM);
    end else if (wr_log[0] !== elem_of(7, ord(0))) begin
      n_err++; $display("FAIL midrst_new_first: got %h, required %h", wr_log[0], elem_of(7, ord(0)));
    end
    if (occupancy !== 4'd4) begin n_err++; $display("FAIL midrst_new_occupancy: got %0d, required 4", occupancy); end
    if (busy !== 1'b0)      begin n_err++; $display("FAIL midrst_new_idle: got %b, required 0", busy); end
    drain();
  endtask

  task automatic test_continuous();
    int acc_cyc[6];
    int n_acc = 0;
    bool_t_dummy: begin end
    fifo_rd_en = 1'b1;
    wr_log.delete();
    in_valid = 1'b1;
    vec_in   = mk_vec(0);
    for (int c = 0; c < 60 && n_acc < 6; c++) begin
      bit acc;
      acc = in_ready;
      if (acc) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      tick();
      if (acc) vec_in = mk_vec(n_acc);
    end
    in_valid = 1'b0;
    repeat (6) tick();
    fifo_rd_en = 1'b0;
    n_vec += 2;
    if (n_acc != 6) begin n_err++; $display("FAIL cont_accept_count: got %0d, required 6", n_acc); end
    if (wr_log.size() != 6 * NUM_ELEM) begin
      n_err++; $display("FAIL cont_write_count: got %0d, required %0d", wr_log.size(), 6 * NUM_ELEM);
    end
    for (int k = 1; k < n_acc; k++) begin
      n_vec++;
      if (acc_cyc[k] - acc_cyc[k-1] != NUM_ELEM + 1) begin
        n_err++; $display("FAIL cont_gap%0d: got %0d cycles, required %0d", k, acc_cyc[k] - acc_cyc[k-1], NUM_ELEM + 1);
      end
    end
    for (int i = 0; i < wr_log.size() && i < 6 * NUM_ELEM; i++) begin
      n_vec++;
      if (wr_log[i] !== elem_of(i / NUM_ELEM, ord(i % NUM_ELEM))) begin
        n_err++;
        $display("FAIL cont_data%0d: got %h, required %h", i, wr_log[i], elem_of(i / NUM_ELEM, ord(i % NUM_ELEM)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stream_read();
    test_reset_mid();
    test_continuous();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
